sm_regscan: RTL and testbench

Controller for the core's debug register-read port (`regAddr`/`regData`) on the board top. It sequences register addresses in one of two modes: auto-scan on a timer, or manual stepping with debounced push-buttons. It samples the addressed register after a settle delay and holds the value and its address stable for the hex displays and LEDs. It replaces direct switch-to-`regAddr` wiring and owns the port exclusively.

---
 rtl/sm_regscan_pkg.sv | 29 ++
 rtl/sm_debounce.sv | 45 ++++
 rtl/sm_regscan.sv | 113 +++++++++++
 tb/tb_sm_regscan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_regscan_pkg.sv
// Shared types and address arithmetic for the debug register-scan controller.
// Holds the FSM state encoding and the address width used by every file of the block.
package sm_regscan_pkg;

   localparam int ADDR_W = 5;
   localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {
      ST_SETTLE = 2'd0,
      ST_SAMPLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   // One step up or down the address ring; address 0 is jumped over when skip_zero is set.
   function automatic logic [ADDR_W-1:0] addr_step(input logic [ADDR_W-1:0] addr,
                                                   input logic              up,
                                                   input logic              skip_zero);
      logic [ADDR_W-1:0] nxt;
      if (up) begin
         nxt = addr + ADDR_W'(1);
         if (skip_zero && nxt == '0) nxt = ADDR_W'(1);
      end else begin
         nxt = addr - ADDR_W'(1);
         if (skip_zero && nxt == '0) nxt = ADDR_MAX;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/sm_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter, and a
// single-cycle pulse on each accepted rising edge of the stable level.
module sm_debounce #(
   parameter int DEBOUNCE = 500_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   logic             sync1;
   logic             sync2;
   logic             stable;
   logic [CNT_W-1:0] cnt;

   // NOTE: state updates use <= so every flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         pulse  <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         pulse <= 1'b0;
         // Any disagreement with the accepted level must persist DEBOUNCE samples in a row.
         if (sync2 == stable) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
            pulse  <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sm_regscan.sv
// Owns the core debug read port: steps regAddr by timer or buttons, waits for
// the read data to settle, then latches value and address for the displays.
module sm_regscan
   import sm_regscan_pkg::*;
#(
   parameter int TICK_DIV   = 25_000_000,
   parameter int DEBOUNCE   = 500_000,
   parameter int SETTLE_CYC = 2,
   parameter bit SKIP_ZERO  = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mode_auto,
   input  logic              btn_next,
   input  logic              btn_prev,
   output logic [ADDR_W-1:0] regAddr,
   input  logic [31:0]       regData,
   output logic [31:0]       disp_word,
   output logic [ADDR_W-1:0] disp_addr,
   output logic              busy
);

   localparam int                TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam int                SET_W     = $clog2(SETTLE_CYC + 1);
   localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYC - 1);
   localparam logic [ADDR_W-1:0] RST_ADDR  = SKIP_ZERO ? ADDR_W'(1) : '0;

   state_t            state, state_nxt;
   logic [SET_W-1:0]  settle_cnt, settle_nxt;
   logic [ADDR_W-1:0] cur_addr, addr_nxt, daddr_nxt;
   logic [31:0]       word_nxt;
   logic [TICK_W-1:0] tick_cnt;
   logic              tick;
   logic              next_pulse;
   logic              prev_pulse;

   sm_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_next (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_next),
      .pulse (next_pulse)
   );

   sm_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_prev (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_prev),
      .pulse (prev_pulse)
   );

   // Free-running divider; the strobe is lost if the FSM is not waiting in HOLD.
   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_SETTLE;
         settle_cnt <= '0;
         cur_addr   <= RST_ADDR;
         disp_word  <= '0;
         disp_addr  <= '0;
      end else begin
         state      <= state_nxt;
         settle_cnt <= settle_nxt;
         cur_addr   <= addr_nxt;
         disp_word  <= word_nxt;
         disp_addr  <= daddr_nxt;
      end
   end

   always_comb begin
      // NOTE: every output gets its hold value first, so no path can leave one unassigned (no latch).
      state_nxt  = state;
      settle_nxt = settle_cnt;
      addr_nxt   = cur_addr;
      word_nxt   = disp_word;
      daddr_nxt  = disp_addr;
      unique case (state)
         ST_SETTLE: begin
            if (settle_cnt == SET_LAST) state_nxt  = ST_SAMPLE;
            else                        settle_nxt = settle_cnt + 1'b1;
         end
         ST_SAMPLE: begin
            word_nxt  = regData;
            daddr_nxt = cur_addr;
            state_nxt = ST_HOLD;
         end
         ST_HOLD: begin
            // Opposing buttons in one cycle cancel out; a coincident tick still counts.
            if (!mode_auto && (next_pulse ^ prev_pulse)) begin
               addr_nxt   = addr_step(cur_addr, next_pulse, SKIP_ZERO);
               settle_nxt = '0;
               state_nxt  = ST_SETTLE;
            end else if (tick) begin
               if (mode_auto) addr_nxt = addr_step(cur_addr, 1'b1, SKIP_ZERO);
               settle_nxt = '0;
               state_nxt  = ST_SETTLE;
            end
         end
         default: state_nxt = ST_SETTLE;
      endcase
   end

   assign regAddr = cur_addr;
   assign busy    = (state != ST_HOLD);

endmodule

// File: tb/tb_sm_regscan.sv
// Scoreboard bench for sm_regscan: expected samples are queued as stimulus is
// applied and retired by a monitor each time a sample completes (busy falls).
module tb_sm_regscan;

   localparam int          TICK_DIV   = 8;
   localparam int          DEBOUNCE   = 4;
   localparam int          SETTLE_CYC = 2;
   localparam logic [31:0] WORD_MASK  = 32'hA5A5_0000;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] word;
   } sample_t;

   logic        clk       = 1'b0;
   logic        rst       = 1'b1;
   logic        mode_auto = 1'b0;
   logic        btn_next  = 1'b0;
   logic        btn_prev  = 1'b0;
   logic        override_en = 1'b0;
   logic [4:0]  regAddr;
   logic [4:0]  disp_addr;
   logic [31:0] regData;
   logic [31:0] disp_word;
   logic        busy;

   sample_t exp_q[$];
   sample_t cur_exp;
   bit      strict    = 1'b1;
   bit      gap_check = 1'b0;
   int      last_cyc  = -1;
   int      cyc       = 0;
   int      n_cmp     = 0;
   int      n_bad     = 0;

   // Core read model: the data word is derived from the address unless overridden.
   assign regData = override_en ? 32'hDEAD_BEEF : ({27'h0, regAddr} ^ WORD_MASK);

   sm_regscan #(
      .TICK_DIV   (TICK_DIV),
      .DEBOUNCE   (DEBOUNCE),
      .SETTLE_CYC (SETTLE_CYC),
      .SKIP_ZERO  (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mode_auto (mode_auto),
      .btn_next  (btn_next),
      .btn_prev  (btn_prev),
      .regAddr   (regAddr),
      .regData   (regData),
      .disp_word (disp_word),
      .disp_addr (disp_addr),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   function automatic sample_t mk(input logic [4:0] a);
      sample_t s;
      s.addr = a;
      s.word = {27'h0, a} ^ WORD_MASK;
      return s;
   endfunction

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         step();
         n++;
      end
      check(tag, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // Sync to a tick-driven busy rise, then advance k cycles.
   task automatic wait_tick_phase(input int k);
      logic prev;
      bit   found = 1'b0;
      int   n = 0;
      prev = busy;
      while (!found && n < 40) begin
         step();
         n++;
         if (busy && !prev) found = 1'b1;
         prev = busy;
      end
      check("tick_phase", 32'(found), 32'd1);
      repeat (k) step();
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      check("idle", 32'(busy), 32'd0);
   endtask

   task automatic press(input bit nxt, input bit prv, input bit bounce);
      if (bounce) begin
         btn_next = nxt; btn_prev = prv; step();
         btn_next = 1'b0; btn_prev = 1'b0; step();
      end
      btn_next = nxt; btn_prev = prv;
      repeat (10) step();
      btn_next = 1'b0; btn_prev = 1'b0;
      repeat (8) step();
   endtask

   initial begin : monitor
      logic    busy_prev;
      sample_t obs_s;
      sample_t exp_s;
      busy_prev = 1'b1;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_prev = 1'b1;
         end else begin
            if (busy_prev && !busy) begin
               obs_s = {disp_addr, disp_word};
               exp_s = cur_exp;
               if (exp_q.size() > 0 && (strict || obs_s == exp_q[0])) exp_s = exp_q.pop_front();
               cur_exp = exp_s;
               check("sample_addr", 32'(disp_addr), 32'(exp_s.addr));
               check("sample_word", disp_word, exp_s.word);
               if (gap_check) begin
                  if (last_cyc >= 0) check("tick_gap", 32'(cyc - last_cyc), 32'(TICK_DIV));
                  last_cyc = cyc;
               end
            end
            busy_prev = busy;
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: run did not complete, %0d compared / %0d mismatched", n_cmp, n_bad);
      $fatal(1);
   end

   initial begin : stimulus
      // Reset state and release.
      cur_exp = mk(5'd1);
      repeat (3) step();
      check("rst_regaddr", 32'(regAddr), 32'd1);
      check("rst_word", disp_word, 32'd0);
      check("rst_daddr", 32'(disp_addr), 32'd0);
      check("rst_busy", 32'(busy), 32'd1);
      exp_q.push_back(mk(5'd1));
      rst = 1'b0;
      #1;
      check("rel_regaddr", 32'(regAddr), 32'd1);
      repeat (3) step();
      check("rel_daddr", 32'(disp_addr), 32'd1);
      check("rel_word", disp_word, 32'hA5A5_0001);
      check("rel_busy", 32'(busy), 32'd0);
      wait_drain("drain_reset", 4);

      // Auto-scan through the full ring, 0 skipped, one step per tick.
      strict = 1'b1;
      gap_check = 1'b1;
      last_cyc = -1;
      for (int i = 2; i <= 31; i++) exp_q.push_back(mk(5'(i)));
      exp_q.push_back(mk(5'd1));
      mode_auto = 1'b1;
      wait_drain("drain_auto", 31 * TICK_DIV + 20);
      gap_check = 1'b0;
      mode_auto = 1'b0;
      strict = 1'b0;

      // Manual next with contact bounce, then two prev steps across the wrap.
      wait_tick_phase(4);
      exp_q.push_back(mk(5'd2));
      press(1'b1, 1'b0, 1'b1);
      wait_drain("drain_next", 40);
      check("next_regaddr", 32'(regAddr), 32'd2);

      wait_tick_phase(0);
      exp_q.push_back(mk(5'd1));
      press(1'b0, 1'b1, 1'b0);
      wait_drain("drain_prev1", 40);
      check("prev1_regaddr", 32'(regAddr), 32'd1);

      wait_tick_phase(0);
      exp_q.push_back(mk(5'd31));
      press(1'b0, 1'b1, 1'b0);
      wait_drain("drain_prev2", 40);
      check("prev2_regaddr", 32'(regAddr), 32'd31);

      // Both buttons in the same cycle, clear of any tick: nothing moves.
      wait_tick_phase(0);
      btn_next = 1'b1;
      btn_prev = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         step();
         if (i >= 4) begin
            check("both_busy", 32'(busy), 32'd0);
            check("both_regaddr", 32'(regAddr), 32'd31);
         end
      end
      repeat (3) step();
      btn_next = 1'b0;
      btn_prev = 1'b0;
      repeat (8) step();
      check("both_final", 32'(regAddr), 32'd31);

      // Reach address 5 by auto-stepping, then manual refresh picks up new data.
      wait_idle();
      strict = 1'b1;
      for (int i = 1; i <= 5; i++) exp_q.push_back(mk(5'(i)));
      mode_auto = 1'b1;
      wait_drain("drain_to5", 6 * TICK_DIV + 10);
      mode_auto = 1'b0;
      override_en = 1'b1;
      exp_q.push_back({5'd5, 32'hDEAD_BEEF});
      wait_drain("drain_refresh", 2 * TICK_DIV + 4);
      check("refresh_word", disp_word, 32'hDEAD_BEEF);
      check("refresh_daddr", 32'(disp_addr), 32'd5);
      override_en = 1'b0;
      exp_q.push_back(mk(5'd5));
      wait_drain("drain_restore", 2 * TICK_DIV + 4);

      // Reset one cycle into the settle of an auto step.
      mode_auto = 1'b1;
      wait_tick_phase(1);
      rst = 1'b1;
      #1;
      check("midrst_regaddr", 32'(regAddr), 32'd1);
      check("midrst_word", disp_word, 32'd0);
      check("midrst_daddr", 32'(disp_addr), 32'd0);
      check("midrst_busy", 32'(busy), 32'd1);
      mode_auto = 1'b0;
      repeat (2) step();
      exp_q.delete();
      cur_exp = mk(5'd1);
      exp_q.push_back(mk(5'd1));
      rst = 1'b0;
      #1;
      check("rerel_regaddr", 32'(regAddr), 32'd1);
      repeat (3) step();
      check("rerel_daddr", 32'(disp_addr), 32'd1);
      check("rerel_word", disp_word, 32'hA5A5_0001);
      check("rerel_busy", 32'(busy), 32'd0);
      wait_drain("drain_rerel", 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
